// File: rtl/multicycle_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// multicycle_ctrl_pkg : opcodes, datapath select encodings and FSM states
// Rev 1.0
// ============================================================================
package multicycle_ctrl_pkg;

  localparam logic [5:0] OP_R     = 6'b000000;
  localparam logic [5:0] OP_ADDIU = 6'b001100;
  localparam logic [5:0] OP_SUBIU = 6'b001101;
  localparam logic [5:0] OP_SW    = 6'b010000;
  localparam logic [5:0] OP_LW    = 6'b010001;
  localparam logic [5:0] OP_BEQ   = 6'b010011;
  localparam logic [5:0] OP_J     = 6'b011100;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;
  localparam logic [1:0] ALU_NONE  = 2'b11;

  localparam logic [1:0] SRCB_REG    = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_ADDI, S_EXEC_SUBI,
    S_WB_R, S_WB_I, S_MEM_ADDR, S_MEM_READ, S_MEM_WB, S_MEM_WRITE,
    S_BRANCH, S_JUMP, S_TRAP
  } state_e;

  // States that wait on the memory handshake and are guarded by the timer.
  function automatic logic is_wait_state(input state_e s);
    return (s == S_FETCH) || (s == S_MEM_READ) || (s == S_MEM_WRITE);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mc_wait_timer.sv
`default_nettype none
// ============================================================================
// mc_wait_timer : memory wait-state counter with timeout detect
// Rev 1.0
// ============================================================================
module mc_wait_timer #(
  parameter int WAIT_W   = 4,
  parameter int MAX_WAIT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic count_en,
  input  logic mem_ready,
  output logic timeout
);

  localparam logic [WAIT_W-1:0] LAST_WAIT = WAIT_W'(MAX_WAIT - 1);

  logic [WAIT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (count_en && !mem_ready) begin
      count_d = count_q + WAIT_W'(1);
    end
  end

  // Fires on the cycle whose unready increment would reach MAX_WAIT.
  assign timeout = (MAX_WAIT != 0) && count_en && !mem_ready && (count_q == LAST_WAIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/multicycle_control.sv
`default_nettype none
// ============================================================================
// multicycle_control : Moore sequencer for the shared-memory multi-cycle CPU
// Rev 1.0
// ============================================================================
module multicycle_control #(
  parameter int OPCODE_W = 6,
  parameter int WAIT_W   = 4,
  parameter int MAX_WAIT = 15,
  parameter int CNT_W    = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                mem_ready,
  output logic                pc_write,
  output logic                pc_write_cond,
  output logic [1:0]          pc_source,
  output logic                i_or_d,
  output logic                mem_read,
  output logic                mem_write,
  output logic                ir_write,
  output logic                mem_to_reg,
  output logic                reg_dst,
  output logic                reg_write,
  output logic                alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic [1:0]          alu_op,
  output logic                illegal_op,
  output logic                bus_err,
  output logic                retired,
  output logic [CNT_W-1:0]    retire_count
);
  import multicycle_ctrl_pkg::*;

  state_e           state_q, state_d;
  logic             illegal_q, illegal_d;
  logic             bus_err_q, bus_err_d;
  logic [CNT_W-1:0] retire_count_q, retire_count_d;
  logic             wait_en, wait_clear, wait_timeout;

  mc_wait_timer #(
    .WAIT_W   (WAIT_W),
    .MAX_WAIT (MAX_WAIT)
  ) u_wait_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (wait_clear),
    .count_en  (wait_en),
    .mem_ready (mem_ready),
    .timeout   (wait_timeout)
  );

  always_comb begin
    state_d       = state_q;
    illegal_d     = illegal_q;
    bus_err_d     = bus_err_q;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_source     = PCSRC_ALU;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = SRCB_REG;
    alu_op        = ALU_NONE;
    retired       = 1'b0;
    case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = SRCB_FOUR;
        alu_op    = ALU_ADD;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = S_DECODE;
        end else if (wait_timeout) begin
          bus_err_d = 1'b1;
          state_d   = S_TRAP;
        end
      end
      S_DECODE: begin
        alu_src_b = SRCB_IMM_SH;
        alu_op    = ALU_ADD;
        case (opcode)
          OP_R:         state_d = S_EXEC_R;
          OP_ADDIU:     state_d = S_EXEC_ADDI;
          OP_SUBIU:     state_d = S_EXEC_SUBI;
          OP_LW, OP_SW: state_d = S_MEM_ADDR;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          default: begin
            illegal_d = 1'b1;
            state_d   = S_TRAP;
          end
        endcase
      end
      S_EXEC_R: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_FUNCT;
        state_d   = S_WB_R;
      end
      S_EXEC_ADDI, S_EXEC_SUBI: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        alu_op    = (state_q == S_EXEC_SUBI) ? ALU_SUB : ALU_ADD;
        state_d   = S_WB_I;
      end
      S_WB_R, S_WB_I: begin
        reg_write = 1'b1;
        reg_dst   = (state_q == S_WB_R);
        retired   = 1'b1;
        state_d   = S_FETCH;
      end
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        alu_op    = ALU_ADD;
        state_d   = (opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
      end
      S_MEM_READ: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
        if (mem_ready) begin
          state_d = S_MEM_WB;
        end else if (wait_timeout) begin
          bus_err_d = 1'b1;
          state_d   = S_TRAP;
        end
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        retired    = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEM_WRITE: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
        if (mem_ready) begin
          retired = 1'b1;
          state_d = S_FETCH;
        end else if (wait_timeout) begin
          bus_err_d = 1'b1;
          state_d   = S_TRAP;
        end
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = ALU_SUB;
        pc_write_cond = 1'b1;
        pc_source     = PCSRC_ALUOUT;
        retired       = 1'b1;
        state_d       = S_FETCH;
      end
      S_JUMP: begin
        pc_write  = 1'b1;
        pc_source = PCSRC_JUMP;
        retired   = 1'b1;
        state_d   = S_FETCH;
      end
      S_TRAP: state_d = S_TRAP;
      default: state_d = S_IDLE;
    endcase
    retire_count_d = retire_count_q + CNT_W'(retired);
  end

  // The timer restarts only when a wait state is freshly entered.
  always_comb begin
    wait_en    = is_wait_state(state_q);
    wait_clear = is_wait_state(state_d) && (state_d != state_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      illegal_q      <= 1'b0;
      bus_err_q      <= 1'b0;
      retire_count_q <= '0;
    end else begin
      state_q        <= state_d;
      illegal_q      <= illegal_d;
      bus_err_q      <= bus_err_d;
      retire_count_q <= retire_count_d;
    end
  end

  assign illegal_op   = illegal_q;
  assign bus_err      = bus_err_q;
  assign retire_count = retire_count_q;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control.sv
`default_nettype none
// ============================================================================
// tb_multicycle_control : directed self-checking bench for multicycle_control
// Rev 1.0
// ============================================================================
module tb_multicycle_control;

  localparam logic [5:0] T_R = 6'b000000, T_ADDIU = 6'b001100, T_SUBIU = 6'b001101;
  localparam logic [5:0] T_SW = 6'b010000, T_LW = 6'b010001, T_BEQ = 6'b010011;
  localparam logic [5:0] T_J = 6'b011100, T_BAD = 6'b111111;

  // {pc_write, pc_write_cond, pc_source, i_or_d, mem_read, mem_write, ir_write,
  //  mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op}
  localparam logic [15:0] E_IDLE       = 16'b0_0_00_0_0_0_0_0_0_0_0_00_11;
  localparam logic [15:0] E_FETCH_WAIT = 16'b0_0_00_0_1_0_0_0_0_0_0_01_00;
  localparam logic [15:0] E_FETCH_RDY  = 16'b1_0_00_0_1_0_1_0_0_0_0_01_00;
  localparam logic [15:0] E_DECODE     = 16'b0_0_00_0_0_0_0_0_0_0_0_11_00;
  localparam logic [15:0] E_EXEC_R     = 16'b0_0_00_0_0_0_0_0_0_0_1_00_10;
  localparam logic [15:0] E_EXEC_SUBI  = 16'b0_0_00_0_0_0_0_0_0_0_1_10_01;
  localparam logic [15:0] E_MEM_ADDR   = 16'b0_0_00_0_0_0_0_0_0_0_1_10_00;
  localparam logic [15:0] E_WB_R       = 16'b0_0_00_0_0_0_0_0_1_1_0_00_11;
  localparam logic [15:0] E_WB_I       = 16'b0_0_00_0_0_0_0_0_0_1_0_00_11;
  localparam logic [15:0] E_MEM_READ   = 16'b0_0_00_1_1_0_0_0_0_0_0_00_11;
  localparam logic [15:0] E_MEM_WB     = 16'b0_0_00_0_0_0_0_1_0_1_0_00_11;
  localparam logic [15:0] E_MEM_WRITE  = 16'b0_0_00_1_0_1_0_0_0_0_0_00_11;
  localparam logic [15:0] E_BRANCH     = 16'b0_1_01_0_0_0_0_0_0_0_1_00_01;
  localparam logic [15:0] E_JUMP       = 16'b1_0_10_0_0_0_0_0_0_0_0_00_11;
  localparam logic [15:0] E_TRAP       = E_IDLE;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] opcode;
  logic       mem_ready;

  logic        pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic        mem_to_reg, reg_dst, reg_write, alu_src_a, illegal_op, bus_err, retired;
  logic [1:0]  pc_source, alu_src_b, alu_op;
  logic [31:0] retire_count;

  logic        d2_pc_write, d2_pc_write_cond, d2_i_or_d, d2_mem_read, d2_mem_write, d2_ir_write;
  logic        d2_mem_to_reg, d2_reg_dst, d2_reg_write, d2_alu_src_a, d2_illegal_op, d2_bus_err;
  logic        d2_retired;
  logic [1:0]  d2_pc_source, d2_alu_src_b, d2_alu_op, d2_retire_count;

  logic [15:0] outs;
  assign outs = {pc_write, pc_write_cond, pc_source, i_or_d, mem_read, mem_write, ir_write,
                 mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op};

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  multicycle_control #(.OPCODE_W(6), .WAIT_W(4), .MAX_WAIT(15), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .pc_source(pc_source),
    .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .illegal_op(illegal_op), .bus_err(bus_err), .retired(retired),
    .retire_count(retire_count)
  );

  multicycle_control #(.OPCODE_W(6), .WAIT_W(4), .MAX_WAIT(15), .CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(d2_pc_write), .pc_write_cond(d2_pc_write_cond), .pc_source(d2_pc_source),
    .i_or_d(d2_i_or_d), .mem_read(d2_mem_read), .mem_write(d2_mem_write),
    .ir_write(d2_ir_write), .mem_to_reg(d2_mem_to_reg), .reg_dst(d2_reg_dst),
    .reg_write(d2_reg_write), .alu_src_a(d2_alu_src_a), .alu_src_b(d2_alu_src_b),
    .alu_op(d2_alu_op), .illegal_op(d2_illegal_op), .bus_err(d2_bus_err),
    .retired(d2_retired), .retire_count(d2_retire_count)
  );

  // Row layout: {opcode[23:18], mem_ready[17], expected retired[16], expected outs[15:0]}
  function automatic logic [23:0] row(input logic [5:0] op, input logic [15:0] e,
                                      input logic ret, input logic rdy);
    return {op, rdy, ret, e};
  endfunction

  // Leaves the DUTs one cycle into FETCH, 1 ns after the clock edge.
  task automatic do_reset();
    rst_n = 1'b0;
    mem_ready = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; opcode = T_R; mem_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (outs !== E_IDLE) $display("FAIL reset_outs got=%b exp=%b", outs, E_IDLE);
    else n_pass++;
    n_checks++;
    if ({illegal_op, bus_err, retired, retire_count, d2_retire_count} !== 37'd0)
      $display("FAIL reset_flags got ill=%b berr=%b ret=%b cnt=%0d cnt2=%0d exp all 0",
               illegal_op, bus_err, retired, retire_count, d2_retire_count);
    else n_pass++;
    rst_n = 1'b1; #1;
    n_checks++;
    if (outs !== E_IDLE) $display("FAIL reset_idle_after_release got=%b exp=%b", outs, E_IDLE);
    else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_r_type();
    logic [23:0] q[$];
    q.push_back(row(T_R, E_FETCH_RDY, 1'b0, 1'b1));
    q.push_back(row(T_R, E_DECODE,    1'b0, 1'b0));
    q.push_back(row(T_R, E_EXEC_R,    1'b0, 1'b0));
    q.push_back(row(T_R, E_WB_R,      1'b1, 1'b0));
    foreach (q[i]) begin
      opcode = q[i][23:18]; mem_ready = q[i][17]; #1;
      n_checks++;
      if ({retired, outs} !== q[i][16:0])
        $display("FAIL r_type cyc%0d got ret=%b outs=%b exp ret=%b outs=%b",
                 i, retired, outs, q[i][16], q[i][15:0]);
      else n_pass++;
      @(posedge clk); #1;
    end
    mem_ready = 1'b0; #1;
    n_checks++;
    if ({retired, retire_count} !== {1'b0, 32'd1})
      $display("FAIL r_type_count got ret=%b cnt=%0d exp ret=0 cnt=1", retired, retire_count);
    else n_pass++;
  endtask

  task automatic test_lw_wait();
    logic [23:0] q[$];
    q.push_back(row(T_LW, E_FETCH_RDY, 1'b0, 1'b1));
    q.push_back(row(T_LW, E_DECODE,    1'b0, 1'b0));
    q.push_back(row(T_LW, E_MEM_ADDR,  1'b0, 1'b0));
    for (int k = 0; k < 3; k++) q.push_back(row(T_LW, E_MEM_READ, 1'b0, 1'b0));
    q.push_back(row(T_LW, E_MEM_READ,  1'b0, 1'b1));
    q.push_back(row(T_LW, E_MEM_WB,    1'b1, 1'b0));
    foreach (q[i]) begin
      opcode = q[i][23:18]; mem_ready = q[i][17]; #1;
      n_checks++;
      if ({retired, outs} !== q[i][16:0])
        $display("FAIL lw_wait cyc%0d got ret=%b outs=%b exp ret=%b outs=%b",
                 i, retired, outs, q[i][16], q[i][15:0]);
      else n_pass++;
      @(posedge clk); #1;
    end
    mem_ready = 1'b0; #1;
    n_checks++;
    if (retire_count !== 32'd2) $display("FAIL lw_count got=%0d exp=2", retire_count);
    else n_pass++;
  endtask

  task automatic test_illegal();
    logic [23:0] q[$];
    q.push_back(row(T_BAD, E_FETCH_RDY, 1'b0, 1'b1));
    q.push_back(row(T_BAD, E_DECODE,    1'b0, 1'b0));
    foreach (q[i]) begin
      opcode = q[i][23:18]; mem_ready = q[i][17]; #1;
      n_checks++;
      if ({retired, outs} !== q[i][16:0])
        $display("FAIL illegal_pre cyc%0d got ret=%b outs=%b exp ret=%b outs=%b",
                 i, retired, outs, q[i][16], q[i][15:0]);
      else n_pass++;
      @(posedge clk); #1;
    end
    for (int c = 0; c < 20; c++) begin
      mem_ready = c[0]; #1;
      n_checks++;
      if ({illegal_op, bus_err, retired, outs, retire_count} !== {3'b100, E_TRAP, 32'd2})
        $display("FAIL illegal_trap cyc%0d got ill=%b berr=%b ret=%b outs=%b cnt=%0d exp 1 0 0 %b 2",
                 c, illegal_op, bus_err, retired, outs, retire_count, E_TRAP);
      else n_pass++;
      @(posedge clk); #1;
    end
    rst_n = 1'b0; #1;
    n_checks++;
    if ({illegal_op, outs} !== {1'b0, E_IDLE})
      $display("FAIL illegal_reset_clear got ill=%b outs=%b exp 0 %b", illegal_op, outs, E_IDLE);
    else n_pass++;
  endtask

  task automatic test_bus_timeout();
    logic [23:0] q[$];
    do_reset();
    opcode = T_R;
    for (int c = 1; c <= 15; c++) begin
      mem_ready = 1'b0; #1;
      n_checks++;
      if ({bus_err, outs} !== {1'b0, E_FETCH_WAIT})
        $display("FAIL timeout_wait cyc%0d got berr=%b outs=%b exp 0 %b", c, bus_err, outs, E_FETCH_WAIT);
      else n_pass++;
      @(posedge clk); #1;
    end
    for (int c = 0; c < 3; c++) begin
      mem_ready = 1'b1; #1;
      n_checks++;
      if ({bus_err, illegal_op, outs} !== {2'b10, E_TRAP})
        $display("FAIL timeout_trap cyc%0d got berr=%b ill=%b outs=%b exp 1 0 %b",
                 c, bus_err, illegal_op, outs, E_TRAP);
      else n_pass++;
      @(posedge clk); #1;
    end
    // Waits in an earlier FETCH must not carry into the next one.
    do_reset();
    for (int k = 0; k < 10; k++) q.push_back(row(T_R, E_FETCH_WAIT, 1'b0, 1'b0));
    q.push_back(row(T_R, E_FETCH_RDY, 1'b0, 1'b1));
    q.push_back(row(T_R, E_DECODE,    1'b0, 1'b0));
    q.push_back(row(T_R, E_EXEC_R,    1'b0, 1'b0));
    q.push_back(row(T_R, E_WB_R,      1'b1, 1'b0));
    for (int k = 0; k < 14; k++) q.push_back(row(T_R, E_FETCH_WAIT, 1'b0, 1'b0));
    q.push_back(row(T_R, E_FETCH_RDY, 1'b0, 1'b1));
    q.push_back(row(T_R, E_DECODE,    1'b0, 1'b0));
    foreach (q[i]) begin
      opcode = q[i][23:18]; mem_ready = q[i][17]; #1;
      n_checks++;
      if ({bus_err, retired, outs} !== {1'b0, q[i][16:0]})
        $display("FAIL timeout_ready_wins cyc%0d got berr=%b ret=%b outs=%b exp 0 %b %b",
                 i, bus_err, retired, outs, q[i][16], q[i][15:0]);
      else n_pass++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_subiu_beq();
    logic [23:0] q[$];
    do_reset();
    q.push_back(row(T_SUBIU, E_FETCH_RDY, 1'b0, 1'b1));
    q.push_back(row(T_SUBIU, E_DECODE,    1'b0, 1'b0));
    q.push_back(row(T_SUBIU, E_EXEC_SUBI, 1'b0, 1'b0));
    q.push_back(row(T_SUBIU, E_WB_I,      1'b1, 1'b0));
    q.push_back(row(T_BEQ,   E_FETCH_RDY, 1'b0, 1'b1));
    q.push_back(row(T_BEQ,   E_DECODE,    1'b0, 1'b0));
    q.push_back(row(T_BEQ,   E_BRANCH,    1'b1, 1'b0));
    foreach (q[i]) begin
      opcode = q[i][23:18]; mem_ready = q[i][17]; #1;
      n_checks++;
      if ({retired, outs} !== q[i][16:0])
        $display("FAIL subiu_beq cyc%0d got ret=%b outs=%b exp ret=%b outs=%b",
                 i, retired, outs, q[i][16], q[i][15:0]);
      else n_pass++;
      @(posedge clk); #1;
    end
    mem_ready = 1'b0; #1;
    n_checks++;
    if (retire_count !== 32'd2) $display("FAIL subiu_beq_count got=%0d exp=2", retire_count);
    else n_pass++;
  endtask

  task automatic test_wrap_and_reset();
    logic [23:0] q[$];
    do_reset();
    for (int k = 0; k < 4; k++) begin
      q.push_back(row(T_J, E_FETCH_RDY, 1'b0, 1'b1));
      q.push_back(row(T_J, E_DECODE,    1'b0, 1'b0));
      q.push_back(row(T_J, E_JUMP,      1'b1, 1'b0));
    end
    q.push_back(row(T_SW, E_FETCH_RDY, 1'b0, 1'b1));
    q.push_back(row(T_SW, E_DECODE,    1'b0, 1'b0));
    q.push_back(row(T_SW, E_MEM_ADDR,  1'b0, 1'b0));
    q.push_back(row(T_SW, E_MEM_WRITE, 1'b0, 1'b0));
    q.push_back(row(T_SW, E_MEM_WRITE, 1'b1, 1'b1));
    q.push_back(row(T_SW, E_FETCH_RDY, 1'b0, 1'b1));
    q.push_back(row(T_SW, E_DECODE,    1'b0, 1'b0));
    q.push_back(row(T_SW, E_MEM_ADDR,  1'b0, 1'b0));
    foreach (q[i]) begin
      opcode = q[i][23:18]; mem_ready = q[i][17]; #1;
      n_checks++;
      if ({retired, outs} !== q[i][16:0])
        $display("FAIL wrap_seq cyc%0d got ret=%b outs=%b exp ret=%b outs=%b",
                 i, retired, outs, q[i][16], q[i][15:0]);
      else n_pass++;
      @(posedge clk); #1;
    end
    mem_ready = 1'b0; #1;
    n_checks++;
    if ({outs, retire_count, d2_retire_count} !== {E_MEM_WRITE, 32'd5, 2'd1})
      $display("FAIL wrap_count got outs=%b cnt=%0d cnt2=%0d exp %b 5 1",
               outs, retire_count, d2_retire_count, E_MEM_WRITE);
    else n_pass++;
    rst_n = 1'b0; #1;
    n_checks++;
    if ({mem_write, outs, retire_count, d2_retire_count} !== {1'b0, E_IDLE, 34'd0})
      $display("FAIL mid_write_reset got wr=%b outs=%b cnt=%0d cnt2=%0d exp 0 %b 0 0",
               mem_write, outs, retire_count, d2_retire_count, E_IDLE);
    else n_pass++;
    @(posedge clk); #1;
    rst_n = 1'b1; #1;
    n_checks++;
    if (outs !== E_IDLE) $display("FAIL restart_idle got=%b exp=%b", outs, E_IDLE);
    else n_pass++;
    @(posedge clk); #1;
    mem_ready = 1'b1; #1;
    n_checks++;
    if (outs !== E_FETCH_RDY) $display("FAIL restart_fetch got=%b exp=%b", outs, E_FETCH_RDY);
    else n_pass++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    opcode = T_R;
    mem_ready = 1'b0;
    test_reset();
    test_r_type();
    test_lw_wait();
    test_illegal();
    test_bus_timeout();
    test_subiu_beq();
    test_wrap_and_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Multi-cycle successor to the single-cycle main control decoder.
- Moore FSM that sequences each instruction through fetch, decode, execute, memory and writeback, driving datapath enables one step per cycle.
- Adds memory wait-state handshaking with a timeout, illegal-opcode trapping and an instruction-retire counter.
- Sits between the instruction register and the shared-memory multi-cycle datapath.

Parameters:
- OPCODE_W, 6, opcode field width.
- WAIT_W, 4, width of the memory wait counter.
- MAX_WAIT, 15, wait cycles tolerated before a bus-error trap; 0 disables the timeout.
- CNT_W, 32, width of retire_count.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, active low
- opcode  in  OPCODE_W  IR[31:26]; stable from DECODE onward
- mem_ready  in  1  memory completed the current read or write this cycle
- pc_write  out  1  unconditional PC load
- pc_write_cond  out  1  PC load if ALU zero
- pc_source  out  2  00 ALU result, 01 ALUOut, 10 jump target
- i_or_d  out  1  memory address select: 0 PC, 1 ALUOut
- mem_read  out  1  memory read strobe
- mem_write  out  1  memory write strobe
- ir_write  out  1  instruction register load
- mem_to_reg  out  1  writeback data select: 1 MDR
- reg_dst  out  1  destination register: 1 rd, 0 rt
- reg_write  out  1  register file write
- alu_src_a  out  1  ALU A: 0 PC, 1 A register
- alu_src_b  out  2  ALU B: 00 B register, 01 constant 4, 10 sign-extended immediate, 11 immediate<<2
- alu_op  out  2  00 add, 01 sub, 10 funct, 11 none
- illegal_op  out  1  sticky: undefined opcode trap
- bus_err  out  1  sticky: memory timeout trap
- retired  out  1  one-cycle pulse when an instruction completes
- retire_count  out  CNT_W  completed instructions, wrapping

Behaviour:
- Reset asserted:
  - State goes to IDLE immediately (asynchronous).
  - All outputs, the wait counter and retire_count clear to 0; alu_op = 11.
- Outputs are decoded from state only. Exception: in FETCH, ir_write and pc_write are mem_ready-qualified.
- Any output not listed for a state is 0, and alu_op = 11.
- Opcodes: R=000000, ADDIU=001100, SUBIU=001101, SW=010000, LW=010001, BEQ=010011, J=011100.
- IDLE: all outputs inactive; -> FETCH after 1 cycle.
- FETCH:
  - mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00.
  - If mem_ready: ir_write=1, pc_write=1, -> DECODE; otherwise stay.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=00. Dispatch on opcode:
  - R -> EXEC_R; ADDIU -> EXEC_ADDI; SUBIU -> EXEC_SUBI.
  - LW or SW -> MEM_ADDR; BEQ -> BRANCH; J -> JUMP.
  - Any other opcode -> TRAP with illegal_op=1.
- EXEC_R: alu_src_a=1, alu_src_b=00, alu_op=10 -> WB_R.
- EXEC_ADDI and EXEC_SUBI: alu_src_a=1, alu_src_b=10; alu_op=00 or 01 respectively -> WB_I.
- WB_R: reg_write=1, reg_dst=1, mem_to_reg=0 -> FETCH, retire.
- WB_I: reg_write=1, reg_dst=0, mem_to_reg=0 -> FETCH, retire.
- MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=00 -> MEM_READ if LW, MEM_WRITE if SW.
- MEM_READ: mem_read=1, i_or_d=1; on mem_ready -> MEM_WB.
- MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0 -> FETCH, retire.
- MEM_WRITE: mem_write=1, i_or_d=1; on mem_ready -> FETCH, retire.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01 -> FETCH, retire.
- JUMP: pc_write=1, pc_source=10 -> FETCH, retire.
- Retire: retired=1 for the cycle leaving a terminal state; retire_count increments the same edge and wraps at 2^CNT_W-1 -> 0.
- Wait counter:
  - Clears on entry to FETCH, MEM_READ and MEM_WRITE.
  - Increments each cycle spent there with mem_ready=0.
  - If MAX_WAIT>0 and the count reaches MAX_WAIT with mem_ready still 0 -> TRAP with bus_err=1.
  - mem_ready=1 on that same cycle wins: normal transition, no trap.
- TRAP: all strobes 0; held until reset. illegal_op and bus_err are never both set.
- Latency with zero wait states: R/ADDIU/SUBIU 4 cycles, LW 5, SW 4, BEQ 3, J 3.

Decomposition:
- Package multicycle_ctrl_pkg holds:
  - opcode constants;
  - ALUOp, alu_src_b and pc_source encodings;
  - state enumeration.
- Sub-module mc_wait_timer holds the wait counter and timeout compare, with inputs clear, count_en and mem_ready and output timeout.

Test Plan:
- Reset release, R opcode, mem_ready=1 -> IDLE, FETCH, DECODE, EXEC_R, WB_R; reg_write=1 and reg_dst=1 in WB_R; retired pulse; retire_count=1.
- LW with mem_ready low 3 cycles in MEM_READ -> mem_read and i_or_d held 3 extra cycles; total 8 cycles; mem_to_reg=1 in writeback.
- Opcode 111111 -> TRAP after DECODE; illegal_op=1 persists 20 cycles; no strobes; retire_count unchanged.
- MAX_WAIT=15, mem_ready held 0 in FETCH -> bus_err=1 on cycle 15; mem_ready=1 exactly on cycle 15 -> no trap, DECODE.
- SUBIU then BEQ -> alu_op=01 in EXEC_SUBI; pc_write_cond=1 and pc_source=01 in BRANCH; retire_count=2.
- rst_n pulsed low mid-MEM_WRITE -> mem_write drops immediately; outputs cleared; restart at IDLE; CNT_W=2 run of 5 instructions -> retire_count wraps to 1.
